// File: rtl/d_sramlike_bridge.sv
// d_sramlike_bridge
//   Data-side bridge between the ME pipeline stage and an SRAM-like bus
//   (req / addr_ok / data_ok). A single-cycle ME access becomes a two-phase
//   bus transaction; d_stall holds ME until the access completes.
//
// Ports
//   clk, rst        clock, synchronous active-low reset
//   mem_en          ME access valid
//   mem_wen         byte write enables (0000 = load)
//   mem_size        load size (0 byte, 1 half, 2 word)
//   mem_addr        byte address
//   mem_wdata       lane-replicated store data
//   mem_cancel      exception/flush in ME
//   longest_stall   OR of all pipeline stall sources
//   mem_rdata       load data returned to the pipeline
//   d_stall         stall request to the pipeline
//   data_req .. data_wdata          bus request side
//   data_addr_ok, data_rdata, data_data_ok   bus response side
module d_sramlike_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_en,
    input  logic [3:0]    mem_wen,
    input  logic [1:0]    mem_size,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    input  logic          mem_cancel,
    input  logic          longest_stall,
    output logic [DW-1:0] mem_rdata,
    output logic          d_stall,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic [DW-1:0] data_rdata,
    input  logic          data_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic [1:0]    cap_size;
    logic          cap_wr;
    logic          discard;

    logic          start;
    logic          drop;
    logic          live_wr;
    logic [1:0]    live_size;

    assign start   = mem_en & ~mem_cancel;
    // Response is thrown away if a cancel was seen earlier or arrives now.
    assign drop    = discard | mem_cancel;
    assign live_wr = |mem_wen;

    // Stores derive bus size from the byte-enable pattern; loads use mem_size.
    always_comb begin
        live_size = mem_size;
        if (live_wr) begin
            case (mem_wen)
                4'b0011, 4'b1100:                   live_size = 2'd1;
                4'b0001, 4'b0010, 4'b0100, 4'b1000: live_size = 2'd0;
                default:                            live_size = 2'd2;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start)          state_nx = data_addr_ok ? WAIT : REQ;
            REQ:  if (data_addr_ok)   state_nx = WAIT;
            WAIT: if (data_data_ok)   state_nx = drop ? IDLE : DONE;
            DONE: if (!longest_stall) state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // In IDLE the bus sees the live ME fields so a zero-wait addr_ok is
    // possible; afterwards the captured copy keeps them stable.
    always_comb begin
        data_req   = 1'b0;
        data_wr    = cap_wr;
        data_size  = cap_size;
        data_addr  = cap_addr;
        data_wdata = cap_wdata;
        if (state == IDLE) begin
            data_req   = start;
            data_wr    = live_wr;
            data_size  = live_size;
            data_addr  = mem_addr;
            data_wdata = mem_wdata;
        end else if (state == REQ) begin
            data_req   = 1'b1;
        end
    end

    assign d_stall = start & (state != DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mem_rdata <= '0;
            discard   <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_size  <= '0;
            cap_wr    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (start) begin
                        cap_addr  <= mem_addr;
                        cap_wdata <= mem_wdata;
                        cap_size  <= live_size;
                        cap_wr    <= live_wr;
                    end
                end
                REQ: begin
                    if (mem_cancel) discard <= 1'b1;
                end
                WAIT: begin
                    if (data_data_ok) begin
                        discard <= 1'b0;
                        if (!drop && !cap_wr) mem_rdata <= data_rdata;
                    end else if (mem_cancel) begin
                        discard <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_d_sramlike_bridge.sv
// tb_d_sramlike_bridge
//   Directed stimulus for d_sramlike_bridge. Stimulus pushes expected bus
//   requests (one entry per cycle data_req should be high), expected stall
//   run lengths and expected retired load data into queues; a monitor on the
//   falling edge pops and compares as the DUT presents each of them.
module tb_d_sramlike_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_cancel;
    logic        longest_stall;
    logic [31:0] mem_rdata;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    d_sramlike_bridge #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_cancel(mem_cancel),
        .longest_stall(longest_stall), .mem_rdata(mem_rdata), .d_stall(d_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
        .data_data_ok(data_data_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    int          stall_q[$];
    logic [31:0] rd_q[$];

    int n_cmp = 0;
    int n_err = 0;
    logic mon_en = 1'b0;
    int stall_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (data_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'(data_req), 32'd0);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    chk("req_addr", data_addr, e.addr);
                    chk("req_wr_size", {29'd0, data_wr, data_size}, {29'd0, e.wr, e.size});
                    chk("req_wdata", data_wdata, e.wdata);
                end
            end
            if (d_stall) begin
                stall_run++;
            end else if (stall_run > 0) begin
                if (stall_q.size() == 0)
                    chk("unexpected_stall_run", 32'(stall_run), 32'd0);
                else
                    chk("stall_len", 32'(stall_run), 32'(stall_q.pop_front()));
                stall_run = 0;
            end
            // Access retires: valid, not cancelled, not stalled anywhere.
            if (mem_en && !mem_cancel && !d_stall && !longest_stall) begin
                if (rd_q.size() == 0)
                    chk("unexpected_retire", 32'd1, 32'd0);
                else
                    chk("mem_rdata", mem_rdata, rd_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_en        = 1'b0;
        mem_wen       = 4'b0000;
        mem_size      = 2'd0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_cancel    = 1'b0;
        longest_stall = 1'b0;
        data_addr_ok  = 1'b0;
        data_rdata    = '0;
        data_data_ok  = 1'b0;
    endtask

    task automatic push_req(input logic [31:0] a, input logic w, input logic [1:0] s,
                            input logic [31:0] wd, input int n);
        req_t e;
        e.addr = a; e.wr = w; e.size = s; e.wdata = wd;
        for (int i = 0; i < n; i++) req_q.push_back(e);
    endtask

    // Access with addr_ok in the request cycle and data_ok one cycle later.
    task automatic fast_access(input logic [31:0] a, input logic [3:0] wen,
                               input logic [1:0] sz, input logic [31:0] wd,
                               input logic [31:0] bus_rd, input logic [1:0] exp_sz,
                               input logic [31:0] exp_rd);
        mem_en = 1'b1; mem_wen = wen; mem_size = sz; mem_addr = a; mem_wdata = wd;
        data_addr_ok = 1'b1;
        push_req(a, |wen, exp_sz, wd, 1);
        stall_q.push_back(2);
        rd_q.push_back(exp_rd);
        cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = bus_rd;
        cyc();
        data_data_ok = 1'b0; data_rdata = '0;
        cyc();
        idle_inputs();
        cyc();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_data_req", 32'(data_req), 32'd0);
        chk("rst_d_stall", 32'(d_stall), 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;
        cyc();

        // Word load, zero-wait address phase.
        fast_access(32'h0000_0100, 4'b0000, 2'd2, 32'd0, 32'hDEAD_BEEF, 2'd2, 32'hDEAD_BEEF);

        // SB to 0x8000_0003, addr_ok after 3 extra cycles; live inputs change
        // while in REQ but the bus must keep the captured values.
        mem_en = 1'b1; mem_wen = 4'b1000; mem_size = 2'd2;
        mem_addr = 32'h8000_0003; mem_wdata = 32'hABAB_ABAB;
        push_req(32'h8000_0003, 1'b1, 2'd0, 32'hABAB_ABAB, 4);
        stall_q.push_back(5);
        rd_q.push_back(32'hDEAD_BEEF);
        cyc();
        mem_addr = 32'hFFFF_FFF0; mem_wdata = 32'h1111_1111;
        cyc();
        cyc();
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
        cyc();
        data_data_ok = 1'b0;
        cyc();
        idle_inputs();
        cyc();

        // Load finishes while another stall source holds the pipeline.
        mem_en = 1'b1; mem_size = 2'd2; mem_addr = 32'h0000_0200;
        longest_stall = 1'b1; data_addr_ok = 1'b1;
        push_req(32'h0000_0200, 1'b0, 2'd2, 32'd0, 1);
        stall_q.push_back(2);
        rd_q.push_back(32'h0BAD_F00D);
        cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
        cyc();
        data_data_ok = 1'b0; data_rdata = 32'h7777_7777;
        cyc();
        cyc();
        longest_stall = 1'b0;
        cyc();
        idle_inputs();
        cyc();

        // Cancel in the same cycle as the request.
        mem_en = 1'b1; mem_cancel = 1'b1; mem_addr = 32'h0000_0001; data_addr_ok = 1'b1;
        @(negedge clk);
        chk("cancel_d_stall", 32'(d_stall), 32'd0);
        chk("cancel_data_req", 32'(data_req), 32'd0);
        cyc();
        idle_inputs();
        cyc();

        // Cancel while waiting for data; response must be discarded.
        mem_en = 1'b1; mem_size = 2'd2; mem_addr = 32'h0000_0300; data_addr_ok = 1'b1;
        push_req(32'h0000_0300, 1'b0, 2'd2, 32'd0, 1);
        stall_q.push_back(1);
        cyc();
        data_addr_ok = 1'b0; mem_cancel = 1'b1;
        cyc();
        mem_en = 1'b0; mem_cancel = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        cyc();
        data_data_ok = 1'b0; data_rdata = '0;
        @(negedge clk);
        chk("discard_keeps_rdata", mem_rdata, 32'h0BAD_F00D);
        cyc();
        fast_access(32'h0000_0400, 4'b0000, 2'd2, 32'd0, 32'hCAFE_F00D, 2'd2, 32'hCAFE_F00D);

        // Reset while in REQ, stale data_ok afterwards, then a normal load.
        mem_en = 1'b1; mem_size = 2'd2; mem_addr = 32'h0000_0500;
        push_req(32'h0000_0500, 1'b0, 2'd2, 32'd0, 2);
        stall_q.push_back(2);
        cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        idle_inputs();
        data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("midrst_mem_rdata", mem_rdata, 32'd0);
        chk("midrst_data_req", 32'(data_req), 32'd0);
        chk("midrst_d_stall", 32'(d_stall), 32'd0);
        cyc();
        data_data_ok = 1'b0; data_rdata = '0;
        cyc();
        fast_access(32'h0000_0600, 4'b0000, 2'd2, 32'd0, 32'h600D_D00D, 2'd2, 32'h600D_D00D);

        // Halfword store: size from byte enables, mem_rdata untouched.
        fast_access(32'h0000_0700, 4'b0011, 2'd0, 32'h1234_1234, 32'h9999_9999, 2'd1, 32'h600D_D00D);

        cyc();
        cyc();
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("stall_q_drained", 32'(stall_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
